// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: one op at a time over a req/ack bus, with lane steering and load extension.
// Optional MEM_ALIGN_EXC_EN: misaligned word/half ops skip the bus and raise exc_adel/exc_ades.
module mem_access_ctrl #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall,
  output logic [31:0] load_data,
  output logic        load_valid,
  output logic        err_timeout,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_RESP  = 2'd2;
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        timeout_q, timeout_d;
  logic        misal_q, misal_d;
  logic [31:0] load_data_q, load_data_d;

  logic [3:0]  be_in;
  logic [31:0] wdata_in;
  logic        misal_in;
  logic [15:0] half_lane;
  logic [7:0]  byte_lane;
  logic [31:0] ext_data;

  always_comb begin
    be_in    = 4'b0000;
    wdata_in = req_wdata;
    case (req_type)
      3'd0: be_in = 4'b1111;
      3'd1, 3'd3: begin
        be_in    = req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_in = {2{req_wdata[15:0]}};
      end
      3'd2, 3'd4: begin
        be_in    = 4'b0001 << req_addr[1:0];
        wdata_in = {4{req_wdata[7:0]}};
      end
      default: be_in = 4'b0000;
    endcase
  end

`ifdef MEM_ALIGN_EXC_EN
  assign misal_in = ((req_type == 3'd0) && (req_addr[1:0] != 2'b00)) ||
                    (((req_type == 3'd1) || (req_type == 3'd3)) && req_addr[0]);
`else
  assign misal_in = 1'b0;
`endif

  // Lane selection uses the latched address; bus_rdata only matters on the ack cycle.
  always_comb begin
    half_lane = addr_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (addr_q[1:0])
      2'd0:    byte_lane = bus_rdata[7:0];
      2'd1:    byte_lane = bus_rdata[15:8];
      2'd2:    byte_lane = bus_rdata[23:16];
      default: byte_lane = bus_rdata[31:24];
    endcase
    case (type_q)
      3'd0:    ext_data = bus_rdata;
      3'd1:    ext_data = {{16{half_lane[15]}}, half_lane};
      3'd2:    ext_data = {{24{byte_lane[7]}}, byte_lane};
      3'd3:    ext_data = {16'h0000, half_lane};
      3'd4:    ext_data = {24'h000000, byte_lane};
      default: ext_data = 32'h0000_0000;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    type_d      = type_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    be_d        = be_q;
    timeout_d   = timeout_q;
    misal_d     = misal_q;
    load_data_d = load_data_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d      = req_we;
          type_d    = req_type;
          addr_d    = req_addr;
          wdata_d   = wdata_in;
          be_d      = be_in;
          cnt_d     = 8'd0;
          timeout_d = 1'b0;
          misal_d   = misal_in;
          if (misal_in) begin
            state_d     = S_RESP;
            load_data_d = 32'h0000_0000;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // An ack in the terminal-count cycle takes priority over the timeout.
        if (bus_ack) begin
          state_d     = S_RESP;
          load_data_d = we_q ? 32'h0000_0000 : ext_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = S_RESP;
          timeout_d   = 1'b1;
          load_data_d = 32'h0000_0000;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      we_q        <= 1'b0;
      type_q      <= 3'd0;
      addr_q      <= 32'h0000_0000;
      wdata_q     <= 32'h0000_0000;
      be_q        <= 4'b0000;
      timeout_q   <= 1'b0;
      misal_q     <= 1'b0;
      load_data_q <= 32'h0000_0000;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      type_q      <= type_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      be_q        <= be_d;
      timeout_q   <= timeout_d;
      misal_q     <= misal_d;
      load_data_q <= load_data_d;
    end
  end

  // Reset gates stall directly so the pipeline is released without waiting for a clock.
  assign stall       = req_valid & ~reset & (state_q != S_RESP);
  assign bus_req     = (state_q == S_ISSUE);
  assign bus_we      = bus_req & we_q;
  assign bus_addr    = {addr_q[31:2], 2'b00};
  assign bus_be      = be_q;
  assign bus_wdata   = wdata_q;
  assign load_data   = load_data_q;
  assign load_valid  = (state_q == S_RESP) & ~we_q & ~timeout_q & ~misal_q;
  assign err_timeout = (state_q == S_RESP) & timeout_q;

`ifdef MEM_ALIGN_EXC_EN
  assign exc_adel = (state_q == S_RESP) & misal_q & ~we_q;
  assign exc_ades = (state_q == S_RESP) & misal_q & we_q;
`else
  assign exc_adel = 1'b0;
  assign exc_ades = 1'b0;
`endif

endmodule
